// File: rtl/seq_shift_add_mult_pkg.sv
// Shared types and flag helper for the shift-add multiplier.
// SEQ_MULT_SIGNED_EN selects two's-complement operands.
package seq_mult_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

  // Widest operand the flag helper can evaluate.
  localparam int MAX_N = 32;

`ifdef SEQ_MULT_SIGNED_EN
  localparam bit SIGNED_MODE = 1'b1;
`else
  localparam bit SIGNED_MODE = 1'b0;
`endif

  // Returns {c, n, v, z} for a 2w-bit product held in the low bits of prod.
  function automatic logic [3:0] flags_f(input logic [2*MAX_N-1:0] prod,
                                         input int w,
                                         input bit signed_mode);
    logic [2*MAX_N-1:0] p;
    logic c, n, z, all1, all0;
    p    = prod;
    c    = 1'b0;
    n    = 1'b0;
    z    = 1'b1;
    all1 = 1'b1;
    all0 = 1'b1;
    for (int i = 0; i < 2*MAX_N; i++) begin
      if (i < 2*w) begin
        if (p[0]) z = 1'b0;
        if (i >= w && p[0]) c = 1'b1;
        if (i == 2*w-1) n = p[0];
        if (i >= w-1) begin
          if (p[0]) all0 = 1'b0;
          else      all1 = 1'b0;
        end
      end
      p = p >> 1;
    end
    return {c, n, (signed_mode ? !(all1 || all0) : c), z};
  endfunction

endpackage

// File: rtl/seq_shift_add_mult_if.sv
// Request/result bundle of the sequential multiplier.
interface seq_shift_add_mult_if #(parameter int N = 4);
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] r;
  logic           c;
  logic           n;
  logic           v;
  logic           z;

  modport master (output start, a, b, input busy, done, r, c, n, v, z);
  modport slave  (input start, a, b, output busy, done, r, c, n, v, z);
endinterface

// File: rtl/seq_shift_add_mult_rca.sv
// N-bit ripple-carry adder built from a chain of full-adder cells.
module rca_n #(parameter int N = 4) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);
  logic [N:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign s[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[N];
endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier, one add per clock, start/done handshake.
// Define SEQ_MULT_SIGNED_EN for two's-complement operands.
import seq_mult_pkg::*;

module seq_shift_add_mult #(parameter int N = 4) (
  input  logic clk,
  input  logic rst_n,
  seq_shift_add_mult_if.slave bus
);
  localparam int CW = $clog2(N+1);

  mult_state_t        state;
  logic [CW-1:0]      cnt;
  logic [N-1:0]       mcand, acc, mplr;
  logic [N-1:0]       addend, sum_lo, op_a, op_b;
  logic               sum_hi;
  logic               accept;
  logic               busy_q, done_q;
  logic [2*N-1:0]     prod, res, r_q;
  logic [3:0]         flags_q, flags_nxt;
  logic [2*MAX_N-1:0] prod_wide;

  assign accept = bus.start && (state != RUN);
  assign addend = mplr[0] ? mcand : '0;
  assign prod   = {acc, mplr};

`ifdef SEQ_MULT_SIGNED_EN
  logic sign_q;
  assign op_a = bus.a[N-1] ? -bus.a : bus.a;
  assign op_b = bus.b[N-1] ? -bus.b : bus.b;
  assign res  = sign_q ? -prod : prod;
`else
  assign op_a = bus.a;
  assign op_b = bus.b;
  assign res  = prod;
`endif

  rca_n #(.N(N)) u_add (
    .a    (acc),
    .b    (addend),
    .cin  (1'b0),
    .s    (sum_lo),
    .cout (sum_hi)
  );

  always_comb begin
    prod_wide          = '0;
    prod_wide[2*N-1:0] = res;
    flags_nxt          = flags_f(prod_wide, N, SIGNED_MODE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; later assignments in the block win.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      mcand   <= '0;
      acc     <= '0;
      mplr    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_q     <= '0;
      flags_q <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        RUN: begin
          // {acc,mplr} <= {sum,mplr} >> 1
          acc  <= {sum_hi, sum_lo[N-1:1]};
          mplr <= {sum_lo[0], mplr[N-1:1]};
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(N-1)) begin
            state  <= DONE;
            busy_q <= 1'b0;
          end
        end
        DONE: begin
          r_q     <= res;
          flags_q <= flags_nxt;
          done_q  <= 1'b1;
          state   <= IDLE;
        end
        default: ;
      endcase
      // A start in DONE both publishes the old result and launches the next one.
      if (accept) begin
        mcand  <= op_a;
        acc    <= '0;
        mplr   <= op_b;
        cnt    <= '0;
        busy_q <= 1'b1;
        state  <= RUN;
`ifdef SEQ_MULT_SIGNED_EN
        sign_q <= bus.a[N-1] ^ bus.b[N-1];
`endif
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.r    = r_q;
  assign {bus.c, bus.n, bus.v, bus.z} = flags_q;
endmodule
